// File: rtl/float_divider_iterative.sv
// rtl/float_divider_iterative.sv - Iterative radix-2 IEEE-754 binary32 divider with RISC-V fflags
module float_divider_iterative #(
    parameter int QUOTIENT_BITS = 27
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [2:0]  round_mode_i,
    output logic [31:0] result_o,
    output logic        data_valid_o,
    output logic        idle_o,
    output logic        invalid_o,
    output logic        divide_by_zero_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);
    localparam int QB = QUOTIENT_BITS;
    localparam int CW = $clog2(QB + 1);
    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] MIN_EXP = -10'sd126;
    localparam logic signed [9:0] MAX_EXP = 10'sd127;
    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef enum logic [2:0] {
        S_IDLE, S_PRENORM, S_DIVIDE, S_NORMALIZE, S_ROUND, S_OUTPUT, S_SPECIAL
    } state_t;

    state_t             r_state;
    logic               r_sign;
    logic [2:0]         r_rm;
    logic [7:0]         r_a_exp, r_b_exp;
    logic [23:0]        r_a_sig, r_b_sig;
    logic [24:0]        r_rem;
    logic [23:0]        r_div;
    logic [QB-1:0]      r_quot;
    logic [CW-1:0]      r_count;
    logic signed [9:0]  r_exp;
    logic [22:0]        r_frac;
    round_bits_t        r_grs;
    logic [31:0]        r_res;
    logic [4:0]         r_flags;

    logic [7:0]  w_a_exp, w_b_exp;
    logic [22:0] w_a_frac, w_b_frac;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic        w_sign, w_special;
    logic [31:0] w_spec_res;
    logic [4:0]  w_spec_flags;

    assign w_a_exp   = dividend_i[30:23];
    assign w_b_exp   = divisor_i[30:23];
    assign w_a_frac  = dividend_i[22:0];
    assign w_b_frac  = divisor_i[22:0];
    assign w_a_zero  = (w_a_exp == 8'h00) && (w_a_frac == 23'd0);
    assign w_b_zero  = (w_b_exp == 8'h00) && (w_b_frac == 23'd0);
    assign w_a_inf   = (w_a_exp == 8'hFF) && (w_a_frac == 23'd0);
    assign w_b_inf   = (w_b_exp == 8'hFF) && (w_b_frac == 23'd0);
    assign w_a_nan   = (w_a_exp == 8'hFF) && (w_a_frac != 23'd0);
    assign w_b_nan   = (w_b_exp == 8'hFF) && (w_b_frac != 23'd0);
    assign w_a_snan  = w_a_nan && !w_a_frac[22];
    assign w_b_snan  = w_b_nan && !w_b_frac[22];
    assign w_sign    = dividend_i[31] ^ divisor_i[31];
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    // Flags are packed {NV, DZ, OF, UF, NX} throughout.
    always_comb begin
        w_spec_res   = {w_sign, 31'd0};
        w_spec_flags = 5'b00000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res   = CANONICAL_NAN;
            w_spec_flags = {w_a_snan | w_b_snan, 4'b0000};
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res   = CANONICAL_NAN;
            w_spec_flags = 5'b10000;
        end else if (w_b_zero) begin
            w_spec_res   = {w_sign, 8'hFF, 23'd0};
            w_spec_flags = 5'b01000;
        end else if (w_a_inf) begin
            w_spec_res   = {w_sign, 8'hFF, 23'd0};
        end
    end

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && !v[i]) n = n + 5'd1;
            else found = 1'b1;
        end
        return n;
    endfunction

    logic [4:0]        w_a_lzc, w_b_lzc;
    logic [23:0]       w_a_norm, w_b_norm;
    logic signed [9:0] w_a_eff, w_b_eff;

    // Subnormals are shifted up to a leading one; their exponent becomes 1 - lzc.
    assign w_a_lzc  = lzc24(r_a_sig);
    assign w_b_lzc  = lzc24(r_b_sig);
    assign w_a_norm = r_a_sig << w_a_lzc;
    assign w_b_norm = r_b_sig << w_b_lzc;
    assign w_a_eff  = $signed({2'b00, (r_a_exp == 8'd0) ? 8'd1 : r_a_exp}) - $signed({5'd0, w_a_lzc});
    assign w_b_eff  = $signed({2'b00, (r_b_exp == 8'd0) ? 8'd1 : r_b_exp}) - $signed({5'd0, w_b_lzc});

    logic        w_ge;
    logic [23:0] w_sub;

    assign w_ge  = r_rem >= {1'b0, r_div};
    assign w_sub = r_rem[23:0] - r_div;

    logic [QB-2:0] w_qn;

    assign w_qn = r_quot[QB-1] ? r_quot[QB-2:0] : {r_quot[QB-3:0], 1'b0};

    logic              w_any, w_inc, w_ovf_max;
    logic [23:0]       w_frac_inc;
    logic signed [9:0] w_exp_rnd;
    logic [31:0]       w_rnd_res;
    logic [4:0]        w_rnd_flags;

    assign w_any = r_grs.guard | r_grs.round | r_grs.sticky;

    always_comb begin
        w_inc     = 1'b0;
        w_ovf_max = 1'b0;
        case (r_rm)
            RM_RTZ: begin w_inc = 1'b0;              w_ovf_max = 1'b1;    end
            RM_RDN: begin w_inc = r_sign & w_any;    w_ovf_max = ~r_sign; end
            RM_RUP: begin w_inc = ~r_sign & w_any;   w_ovf_max = r_sign;  end
            RM_RMM: begin w_inc = r_grs.guard;       w_ovf_max = 1'b0;    end
            default: begin
                w_inc     = r_grs.guard & (r_grs.round | r_grs.sticky | r_frac[0]);
                w_ovf_max = 1'b0;
            end
        endcase
    end

    // A carry out of the fraction leaves zeros below it, i.e. a renormalized 1.0.
    assign w_frac_inc = {1'b0, r_frac} + {23'd0, w_inc};
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_frac_inc[23]});

    always_comb begin
        w_rnd_res   = {r_sign, w_exp_rnd[7:0], w_frac_inc[22:0]};
        w_rnd_flags = {4'b0000, w_any};
        if (r_exp < MIN_EXP + BIAS) begin
            w_rnd_res   = {r_sign, 31'd0};
            w_rnd_flags = 5'b00011;
        end else if (w_exp_rnd > MAX_EXP + BIAS) begin
            w_rnd_res   = w_ovf_max ? {r_sign, 31'h7F7F_FFFF} : {r_sign, 8'hFF, 23'd0};
            w_rnd_flags = 5'b00101;
        end
    end

    assign idle_o = (r_state == S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state          <= S_IDLE;
            r_sign           <= 1'b0;
            r_rm             <= RM_RNE;
            r_a_exp          <= '0;
            r_b_exp          <= '0;
            r_a_sig          <= '0;
            r_b_sig          <= '0;
            r_rem            <= '0;
            r_div            <= '0;
            r_quot           <= '0;
            r_count          <= '0;
            r_exp            <= '0;
            r_frac           <= '0;
            r_grs            <= '0;
            r_res            <= '0;
            r_flags          <= '0;
            result_o         <= '0;
            data_valid_o     <= 1'b0;
            invalid_o        <= 1'b0;
            divide_by_zero_o <= 1'b0;
            overflow_o       <= 1'b0;
            underflow_o      <= 1'b0;
            inexact_o        <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            if (flush_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (valid_i) begin
                            r_sign  <= w_sign;
                            r_rm    <= (round_mode_i > RM_RMM) ? RM_RNE : round_mode_i;
                            r_a_exp <= w_a_exp;
                            r_b_exp <= w_b_exp;
                            r_a_sig <= {|w_a_exp, w_a_frac};
                            r_b_sig <= {|w_b_exp, w_b_frac};
                            r_res   <= w_spec_res;
                            r_flags <= w_spec_flags;
                            r_state <= w_special ? S_SPECIAL : S_PRENORM;
                        end
                    end
                    S_PRENORM: begin
                        r_rem   <= {1'b0, w_a_norm};
                        r_div   <= w_b_norm;
                        r_exp   <= w_a_eff - w_b_eff + BIAS;
                        r_quot  <= '0;
                        r_count <= '0;
                        r_state <= S_DIVIDE;
                    end
                    S_DIVIDE: begin
                        r_quot  <= {r_quot[QB-2:0], w_ge};
                        r_rem   <= w_ge ? {w_sub, 1'b0} : {r_rem[23:0], 1'b0};
                        r_count <= r_count + 1'b1;
                        if (r_count == CW'(QB - 1)) r_state <= S_NORMALIZE;
                    end
                    S_NORMALIZE: begin
                        r_frac  <= w_qn[QB-2 -: 23];
                        r_grs   <= {w_qn[QB-25], w_qn[QB-26], (|w_qn[QB-27:0]) | (|r_rem)};
                        if (!r_quot[QB-1]) r_exp <= r_exp - 10'sd1;
                        r_state <= S_ROUND;
                    end
                    S_ROUND: begin
                        r_res   <= w_rnd_res;
                        r_flags <= w_rnd_flags;
                        r_state <= S_OUTPUT;
                    end
                    S_OUTPUT, S_SPECIAL: begin
                        result_o     <= r_res;
                        {invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o} <= r_flags;
                        data_valid_o <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_float_divider_iterative.sv
// tb/tb_float_divider_iterative.sv - Self-checking bench for float_divider_iterative
`timescale 1ns/1ps
module tb_float_divider_iterative;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [2:0]  round_mode_i = '0;
    logic [31:0] result_o;
    logic        data_valid_o, idle_o;
    logic        invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o;

    float_divider_iterative #(.QUOTIENT_BITS(27)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .valid_i(valid_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .round_mode_i(round_mode_i),
        .result_o(result_o), .data_valid_o(data_valid_o), .idle_o(idle_o),
        .invalid_o(invalid_o), .divide_by_zero_o(divide_by_zero_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .inexact_o(inexact_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        cur;
    vec_t        vecs[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_fl = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: exact long division of the significands with a wide integer,
    // then IEEE rounding from the discarded bits and the remainder.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm_in,
                                  output logic [31:0] res, output logic [4:0] fl, output bit special);
        logic [2:0]   rm;
        logic         s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
        logic [23:0]  ma, mb;
        logic [127:0] num, quo, remd, mask;
        logic [24:0]  m;
        logic         g, rest, inc;
        int           ea, eb, p, e;
        rm      = (rm_in > 3'd4) ? 3'd0 : rm_in;
        s       = a[31] ^ b[31];
        a_zero  = a[30:0] == 31'd0;
        b_zero  = b[30:0] == 31'd0;
        a_inf   = a[30:23] == 8'hFF && a[22:0] == 23'd0;
        b_inf   = b[30:23] == 8'hFF && b[22:0] == 23'd0;
        a_nan   = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        b_nan   = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        a_snan  = a_nan && !a[22];
        b_snan  = b_nan && !b[22];
        fl      = 5'b00000;
        special = 1'b1;
        res     = {s, 31'd0};
        if (a_nan || b_nan) begin
            res = 32'h7FC00000; fl[4] = a_snan | b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 32'h7FC00000; fl[4] = 1'b1;
        end else if (b_zero) begin
            res = {s, 8'hFF, 23'd0}; fl[3] = 1'b1;
        end else if (a_inf) begin
            res = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            res = {s, 31'd0};
        end else begin
            special = 1'b0;
            ma   = {a[30:23] != 8'd0, a[22:0]};
            mb   = {b[30:23] != 8'd0, b[22:0]};
            ea   = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
            eb   = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
            num  = {104'd0, ma} << 80;
            quo  = num / {104'd0, mb};
            remd = num % {104'd0, mb};
            p = 0;
            for (int i = 0; i < 128; i++) if (quo[i]) p = i;
            e    = p + ea - eb - 80 + 127;
            m    = 25'(quo >> (p - 23));
            g    = quo[p - 24];
            mask = (128'd1 << (p - 24)) - 128'd1;
            rest = ((quo & mask) != 128'd0) || (remd != 128'd0);
            if (e <= 0) begin
                res = {s, 31'd0}; fl = 5'b00011;
            end else begin
                case (rm)
                    3'd1:    inc = 1'b0;
                    3'd2:    inc = s & (g | rest);
                    3'd3:    inc = !s & (g | rest);
                    3'd4:    inc = g;
                    default: inc = g & (rest | m[0]);
                endcase
                m = m + {24'd0, inc};
                if (m[24]) begin m = m >> 1; e++; end
                if (e >= 255) begin
                    fl = 5'b00101;
                    if (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) res = {s, 31'h7F7FFFFF};
                    else res = {s, 8'hFF, 23'd0};
                end else begin
                    res   = {s, 8'(e), m[22:0]};
                    fl[0] = g | rest;
                end
            end
        end
    endfunction

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {63'd0, data_valid_o}, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("result", {32'd0, result_o}, {32'd0, cur.res});
                    chk("flags", {59'd0, invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o},
                        {59'd0, cur.fl});
                    chk("latency", 64'(cyc), 64'(cur.cyc));
                    chk("idle_at_pulse", {63'd0, idle_o}, 64'd1);
                    last_res = cur.res;
                    last_fl  = cur.fl;
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
                chk("missing_pulse", {63'd0, data_valid_o}, 64'd1);
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0) begin
                chk("busy_idle", {63'd0, idle_o}, 64'd0);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (idle_o && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("wait_idle_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm, input bit track);
        logic [31:0] r;
        logic [4:0]  f;
        bit          sp;
        exp_t        e;
        wait_idle();
        dividend_i   = a;
        divisor_i    = b;
        round_mode_i = rm;
        valid_i      = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i      = 1'b0;
        dividend_i   = $urandom;
        divisor_i    = $urandom;
        round_mode_i = 3'($urandom);
        if (track) begin
            model(a, b, rm, r, f, sp);
            e.res = r;
            e.fl  = f;
            e.cyc = cyc + (sp ? 1 : 31);
            exp_q.push_back(e);
        end
    endtask

    function automatic void add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                                input logic [31:0] res, input logic [4:0] fl, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.res = res; v.fl = fl; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        bit          sp;

        // flags column is {NV, DZ, OF, UF, NX}
        add(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 31);
        add(32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 31);
        add(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 31);
        add(32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001, 31);
        add(32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00001, 31);
        add(32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 5'b00001, 31);
        add(32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 5'b00001, 31);
        add(32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001, 31);
        add(32'h40000000, 32'h40400000, 3'd0, 32'h3F2AAAAB, 5'b00001, 31);
        add(32'h3FC00000, 32'h3F800000, 3'd0, 32'h3FC00000, 5'b00000, 31);
        add(32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000, 1);
        add(32'h00000000, 32'h80000000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        add(32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        add(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, 1);
        add(32'hFF800000, 32'hFF800000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        add(32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, 5'b00000, 1);
        add(32'h3F800000, 32'h7F800000, 3'd0, 32'h00000000, 5'b00000, 1);
        add(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000, 1);
        add(32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'b00101, 31);
        add(32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 31);
        add(32'h7F7FFFFF, 32'hBF000000, 3'd3, 32'hFF7FFFFF, 5'b00101, 31);
        add(32'h7F7FFFFF, 32'h3F000000, 3'd2, 32'h7F7FFFFF, 5'b00101, 31);
        add(32'hFF7FFFFF, 32'h3F000000, 3'd2, 32'hFF800000, 5'b00101, 31);
        add(32'h00400000, 32'h3F000000, 3'd0, 32'h00800000, 5'b00000, 31);
        add(32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'b00011, 31);
        add(32'h3F800000, 32'h00400000, 3'd0, 32'h7F000000, 5'b00000, 31);
        add(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 5'b00011, 31);

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_result", {32'd0, result_o}, 64'd0);
        chk("reset_valid", {63'd0, data_valid_o}, 64'd0);
        chk("reset_idle", {63'd0, idle_o}, 64'd1);
        chk("reset_flags", {59'd0, invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o}, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].b, vecs[i].rm, r, f, sp);
            chk($sformatf("model_res_%0d", i), {32'd0, r}, {32'd0, vecs[i].res});
            chk($sformatf("model_flags_%0d", i), {59'd0, f}, {59'd0, vecs[i].fl});
            chk($sformatf("model_lat_%0d", i), sp ? 64'd1 : 64'd31, 64'(vecs[i].lat));
            issue(vecs[i].a, vecs[i].b, vecs[i].rm, 1'b1);
        end

        // A second request while busy must be dropped, not queued.
        issue(32'h3F800000, 32'h40400000, 3'd0, 1'b1);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        valid_i    = 1'b1;
        dividend_i = 32'h3F800000;
        divisor_i  = 32'h00000000;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk_i);
        chk("busy_valid_dropped_idle", {63'd0, idle_o}, 64'd1);

        // Flush mid-operation: no pulse, outputs held.
        issue(32'h40C00000, 32'h40000000, 3'd0, 1'b0);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_idle", {63'd0, idle_o}, 64'd1);
        chk("flush_result_held", {32'd0, result_o}, {32'd0, last_res});
        chk("flush_flags_held", {59'd0, invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o},
            {59'd0, last_fl});
        repeat (40) @(negedge clk_i);

        // Flush together with valid drops the operands.
        dividend_i = 32'h3F800000;
        divisor_i  = 32'h00000000;
        valid_i    = 1'b1;
        flush_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_valid_idle", {63'd0, idle_o}, 64'd1);
        repeat (5) @(negedge clk_i);

        // Asynchronous reset in the middle of the divide.
        issue(32'h3F800000, 32'h40400000, 3'd0, 1'b0);
        repeat (10) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_reset_result", {32'd0, result_o}, 64'd0);
        chk("async_reset_valid", {63'd0, data_valid_o}, 64'd0);
        chk("async_reset_idle", {63'd0, idle_o}, 64'd1);
        chk("async_reset_flags", {59'd0, invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o}, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int k = 0; k < 24; k++) begin
            issue($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/float_divider_iterative.md
Name: float_divider_iterative

Overview:
- Multi-cycle IEEE-754 binary32 divider in the floating point unit; consumes float32_t operands and produces a rounded float32_t result plus RISC-V fflags.
- Sits downstream of the FPU operand/issue stage and upstream of the FPU result writeback mux.
- Radix-2 restoring division of significands, one quotient bit per cycle, followed by normalize and round stages.
- Uses the FPU package's BIAS, MIN_EXP, MAX_EXP, CANONICAL_NAN and round_bits_t.

Parameters:
- QUOTIENT_BITS, 27, number of quotient bits produced: 24 significand bits, 1 normalization spare bit, guard bit and round bit. Values below 27 are illegal.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- flush_i  input  1  abort the current operation; no result is produced.
- valid_i  input  1  operands valid; accepted only when idle_o=1.
- dividend_i  input  32  float32_t dividend.
- divisor_i  input  32  float32_t divisor.
- round_mode_i  input  3  RISC-V rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RNE.
- result_o  output  32  float32_t quotient.
- data_valid_o  output  1  single-cycle pulse; result_o and the flags are valid.
- idle_o  output  1  unit can accept operands.
- invalid_o, divide_by_zero_o, overflow_o, underflow_o, inexact_o  output  1 each  fflags NV, DZ, OF, UF, NX; valid with data_valid_o.

Behaviour:
- Reset (async): state IDLE, idle_o=1, data_valid_o=0, result_o=0, all flags 0.
- Operand and round_mode_i latch on acceptance (valid_i & idle_o); later input changes are ignored.
- valid_i while busy is ignored and is not queued.
- States: IDLE -> PRENORM -> DIVIDE -> NORMALIZE -> ROUND -> IDLE. The special-case path goes IDLE -> SPECIAL -> IDLE.
- idle_o=1 only in IDLE. data_valid_o is a registered 1-cycle pulse; result_o and the flags hold until the next pulse.
- Special cases are detected at acceptance; the result pulses the cycle after acceptance (latency 1). Sign is the XOR of operand signs.
  - Any NaN operand -> CANONICAL_NAN; NV=1 only if an operand is sNaN.
  - 0/0 or inf/inf -> CANONICAL_NAN, NV=1.
  - finite nonzero/0 -> signed infinity, DZ=1.
  - inf/finite -> signed infinity, no flags.
  - 0/nonzero or finite/inf -> signed zero, no flags.
- Normal path latency is exactly 31 cycles from the acceptance edge to the data_valid_o pulse: PRENORM 1, DIVIDE 27, NORMALIZE 1, ROUND 1, output register 1.
- PRENORM: subnormal operands are normalized with a leading-zero count and left shift, and the exponent is adjusted to 1-lzc. The exponent is a 10-bit signed value: ea - eb + BIAS.
- DIVIDE: restoring division over 24-bit significands in [1,2); the quotient lies in (0.5,2).
- NORMALIZE:
  - If quotient MSB=0, shift left 1 and decrement exponent.
  - Guard and round are the next two bits after the 24-bit significand.
  - Sticky = (remainder != 0).
- ROUND: increment decision from mode, sign, LSB, guard, round and sticky.
  - A carry-out renormalizes to 1.0 and increments the exponent.
  - NX = guard|round|sticky.
- Overflow (exponent ≥ 255 after rounding): OF=1, NX=1.
  - RNE/RMM -> inf.
  - RTZ -> max finite (0x7F7FFFFF magnitude).
  - RDN -> +max or -inf.
  - RUP -> +inf or -max.
- Underflow (exponent ≤ 0 before rounding): the result is flushed to signed zero, UF=1, NX=1. Subnormal results are not produced.
- flush_i in any state: next cycle IDLE, no pulse, outputs unchanged. flush_i in the same cycle as valid_i: the operands are dropped.
- Reset mid-operation: immediately IDLE with all outputs cleared.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> result 0x40400000 exactly 31 cycles after accept, all flags 0, idle_o=0 throughout.
- 0x3F800000 / 0x40400000: RNE -> 0x3EAAAAAB NX=1; RTZ -> 0x3EAAAAAA NX=1; RUP -> 0x3EAAAAAB.
- Special cases, each with latency 1:
  - 0x3F800000 / 0x00000000 -> 0x7F800000 DZ=1.
  - 0x00000000 / 0x80000000 -> 0x7FC00000 NV=1.
  - 0x7FA00000 / 0x3F800000 -> 0x7FC00000 NV=1.
- 0x7F7FFFFF / 0x3F000000: RNE -> 0x7F800000 OF=NX=1; RTZ -> 0x7F7FFFFF; sign-flipped divisor with RUP -> 0xFF7FFFFF.
- Subnormal and tiny operands:
  - 0x00400000 / 0x3F000000 -> 0x00800000, no flags.
  - 0x00800000 / 0x40000000 -> 0x00000000 UF=NX=1.
- Control corners:
  - valid_i pulsed at cycle 5 of a busy operation -> ignored, first result unaffected.
  - flush_i at cycle 10 -> no pulse, idle_o=1 next cycle.
  - rst_n_i low mid-DIVIDE -> all outputs 0 asynchronously.
